// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit_serializer block.
//
// Contents:
//   state_e    - serializer FSM state (IDLE: waiting for a word, SHIFT: emitting bits)
//   cnt_width  - width of the bit counter for a given DATA_WIDTH
package bit_serializer_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   // Counter counts DATA_WIDTH-1 down to 0, so $clog2(DATA_WIDTH) bits suffice.
   // A one-bit floor keeps degenerate widths from producing a zero-width vector.
   function automatic int unsigned cnt_width(input int unsigned data_width);
      int unsigned w;
      w = $clog2(data_width);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/word_bit_reverse.sv
// Combinational bit reverser: dout[i] = din[WIDTH-1-i].
// Sits on the serializer's load path so a word can be emitted LSB-first.
//
// Parameters:
//   WIDTH - word width
// Ports:
//   din   - input word
//   dout  - bit-reversed word
module word_bit_reverse #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   always_comb begin
      dout = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         dout[i] = din[WIDTH-1-i];
      end
   end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial transmitter. A DATA_WIDTH-bit word is accepted over a valid/ready
// handshake and emitted one bit per transfer on a serial valid/ready stream, MSB-first.
// dout_last flags the final bit of each word. A new word can be taken on the cycle the
// last bit transfers, so continuous traffic has no bubbles.
//
// Optional feature (macro BIT_SERIALIZER_REVERSE_EN):
//   Adds input rev. When rev=1 on the accepting cycle the word is loaded bit-reversed and
//   therefore emitted LSB-first. Without the macro the port is absent and order is MSB-first.
//
// Parameters:
//   DATA_WIDTH - parallel word width (>= 2)
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset
//   din        - parallel word
//   din_valid  - din holds a word
//   din_ready  - word can be accepted this cycle (combinational)
//   dout       - current serial bit
//   dout_valid - dout carries a valid bit
//   dout_ready - downstream takes dout this cycle
//   rev        - (macro only) emit this word LSB-first
//   dout_last  - dout is the final bit of the word
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic                  dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
`ifdef BIT_SERIALIZER_REVERSE_EN
   input  logic                  rev,
`endif
   output logic                  dout_last
);

   localparam int unsigned           CntWidth = cnt_width(DATA_WIDTH);
   localparam logic [CntWidth-1:0]   CntLoad  = CntWidth'(DATA_WIDTH - 1);

   if (DATA_WIDTH < 2) begin : g_bad_width
      $error("bit_serializer: DATA_WIDTH must be at least 2");
   end

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
   logic [CntWidth-1:0]   cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] load_word;
   logic                  bit_xfer;
   logic                  word_xfer;

   // Outputs come straight from state, so they drop to reset values the moment
   // reset asserts, without waiting for a clock edge.
   assign dout       = sreg_q[DATA_WIDTH-1];
   assign dout_valid = (state_q == SHIFT);
   assign dout_last  = (state_q == SHIFT) && (cnt_q == '0);

   assign bit_xfer  = dout_valid && dout_ready;
   // Ready during the last-bit transfer lets the next word load with no idle cycle.
   assign din_ready = !reset && ((state_q == IDLE) || (bit_xfer && dout_last));
   assign word_xfer = din_valid && din_ready;

`ifdef BIT_SERIALIZER_REVERSE_EN
   logic [DATA_WIDTH-1:0] din_rev;

   word_bit_reverse #(
      .WIDTH (DATA_WIDTH)
   ) u_reverse (
      .din  (din),
      .dout (din_rev)
   );

   // rev only matters here, so changing it mid-word cannot disturb the word in flight.
   assign load_word = rev ? din_rev : din;
`else
   assign load_word = din;
`endif

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;

      if (word_xfer) begin
         // Covers both the IDLE accept and the reload on a last-bit transfer.
         state_d = SHIFT;
         sreg_d  = load_word;
         cnt_d   = CntLoad;
      end else if (bit_xfer) begin
         // Shifting on the last bit too leaves sreg all-zero in IDLE, so dout idles low.
         sreg_d = sreg_q << 1;
         if (dout_last) begin
            state_d = IDLE;
         end else begin
            // dout_last low in SHIFT implies cnt_q > 0, so this never wraps.
            cnt_d = cnt_q - CntWidth'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer (DATA_WIDTH=8): directed scenarios from the
// block's behaviour plus a randomized run against a queue-based bit-stream model.
module tb_bit_serializer;

   localparam int unsigned W = 8;

   logic         clk;
   logic         reset;
   logic [W-1:0] din;
   logic         din_valid;
   logic         din_ready;
   logic         dout;
   logic         dout_valid;
   logic         dout_ready;
   logic         dout_last;
`ifdef BIT_SERIALIZER_REVERSE_EN
   logic         rev;
`endif

   int n_checks;
   int n_fail;

   bit_serializer #(
      .DATA_WIDTH (W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
`ifdef BIT_SERIALIZER_REVERSE_EN
      .rev        (rev),
`endif
      .dout_last  (dout_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; din = 8'hFF; din_valid = 1'b1; dout_ready = 1'b1;
      #1;
      n_checks++;
      if (din_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_din_ready: got %b expected 0", din_ready);
      end
      tick(); tick();
      @(negedge clk);
      n_checks++;
      if ({dout_valid, dout, dout_last} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_outputs: got v/d/l=%b%b%b expected 000", dout_valid, dout, dout_last);
      end
      din_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: got ready=%b valid=%b expected 1/0", din_ready, dout_valid);
      end
      tick();
   endtask

   task automatic test_single_word();
      logic [W-1:0] w;
      w = 8'hA5;
      din = w; din_valid = 1'b1; dout_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (din_ready !== 1'b1) begin
         n_fail++; $display("FAIL single_accept: got ready=%b expected 1", din_ready);
      end
      tick();
      din_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_checks++;
         if (dout_valid !== 1'b1 || dout !== w[7-i] || dout_last !== (i == 7)
             || din_ready !== (i == 7)) begin
            n_fail++;
            $display("FAIL single_bit[%0d]: got v/d/l/r=%b%b%b%b expected 1%b%b%b", i,
                     dout_valid, dout, dout_last, din_ready, w[7-i], i == 7, i == 7);
         end
         tick();
      end
      @(negedge clk);
      n_checks++;
      if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL single_idle: got valid=%b ready=%b expected 0/1", dout_valid, din_ready);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [15:0] stream;
      stream = '0;
      din = 8'h80; din_valid = 1'b1; dout_ready = 1'b1;
      tick();
      din = 8'h01;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         stream[15-i] = dout;
         n_checks++;
         if (dout_valid !== 1'b1 || din_ready !== (i == 7 || i == 15)
             || dout_last !== (i == 7 || i == 15)) begin
            n_fail++;
            $display("FAIL b2b_cycle[%0d]: got v/r/l=%b%b%b expected 1%b%b", i, dout_valid,
                     din_ready, dout_last, i == 7 || i == 15, i == 7 || i == 15);
         end
         tick();
         if (i == 7) din_valid = 1'b0;
      end
      n_checks++;
      if (stream !== 16'h8001) begin
         n_fail++; $display("FAIL b2b_stream: got %h expected 8001", stream);
      end
      @(negedge clk);
      n_checks++;
      if (dout_valid !== 1'b0) begin
         n_fail++; $display("FAIL b2b_idle: got valid=%b expected 0", dout_valid);
      end
      tick();
   endtask

   task automatic test_stall();
      logic [W-1:0] w;
      logic [W-1:0] stream;
      int           n;
      int           stall;
      int           cyc;
      w = 8'hF0; stream = '0; n = 0; stall = 0; cyc = 0;
      din = w; din_valid = 1'b1; dout_ready = 1'b1;
      tick();
      din_valid = 1'b0;
      while (n < 8 && cyc < 40) begin
         dout_ready = !(n == 2 && stall < 4);
         // Offer a competing word during the stall; it must not be taken.
         din = 8'h00; din_valid = !dout_ready;
         @(negedge clk);
         if (!dout_ready) begin
            n_checks++;
            if (dout_valid !== 1'b1 || dout !== w[7-n] || dout_last !== 1'b0
                || din_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL stall_hold[%0d]: got v/d/l/r=%b%b%b%b expected 1%b00", stall,
                        dout_valid, dout, dout_last, din_ready, w[7-n]);
            end
            stall++;
         end else if (dout_valid) begin
            stream[7-n] = dout;
            n_checks++;
            if (dout_last !== (n == 7)) begin
               n_fail++; $display("FAIL stall_last[%0d]: got %b expected %b", n, dout_last, n == 7);
            end
            n++;
         end
         tick();
         cyc++;
      end
      din_valid = 1'b0; dout_ready = 1'b1;
      n_checks++;
      if (n !== 8) begin
         n_fail++; $display("FAIL stall_count: got %0d transfers expected 8", n);
      end
      n_checks++;
      if (stream !== w) begin
         n_fail++; $display("FAIL stall_stream: got %h expected %h", stream, w);
      end
      @(negedge clk);
      n_checks++;
      if (dout_valid !== 1'b0) begin
         n_fail++; $display("FAIL stall_idle: got valid=%b expected 0", dout_valid);
      end
      tick();
   endtask

   task automatic test_busy_reject();
      logic [15:0] stream;
      stream = '0;
      din = 8'h5A; din_valid = 1'b1; dout_ready = 1'b1;
      tick();
      din_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i == 2) begin
            din = 8'h3C; din_valid = 1'b1;
         end
         @(negedge clk);
         stream[15-i] = dout;
         n_checks++;
         if (dout_valid !== 1'b1 || (i < 8 && din_ready !== (i == 7))) begin
            n_fail++;
            $display("FAIL busy_cycle[%0d]: got valid=%b ready=%b expected 1/%b", i, dout_valid,
                     din_ready, i == 7);
         end
         tick();
         if (i == 7) din_valid = 1'b0;
      end
      n_checks++;
      if (stream !== 16'h5A3C) begin
         n_fail++; $display("FAIL busy_stream: got %h expected 5a3c", stream);
      end
      @(negedge clk);
      n_checks++;
      if (dout_valid !== 1'b0) begin
         n_fail++; $display("FAIL busy_idle: got valid=%b expected 0", dout_valid);
      end
      tick();
   endtask

   task automatic test_reset_mid_word();
      logic [W-1:0] stream;
      stream = '0;
      din = 8'hFF; din_valid = 1'b1; dout_ready = 1'b1;
      tick();
      din_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (dout_valid !== 1'b1 || dout !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre[%0d]: got v/d=%b%b expected 11", i, dout_valid, dout);
         end
         tick();
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if ({dout_valid, dout, dout_last, din_ready} !== 4'b0000) begin
         n_fail++;
         $display("FAIL rstmid_async: got v/d/l/r=%b%b%b%b expected 0000", dout_valid, dout,
                  dout_last, din_ready);
      end
      tick();
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_idle: got valid=%b ready=%b expected 0/1", dout_valid, din_ready);
      end
      din = 8'h01; din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         stream[7-i] = dout;
         n_checks++;
         if (dout_valid !== 1'b1 || dout_last !== (i == 7)) begin
            n_fail++;
            $display("FAIL rstmid_bit[%0d]: got v/l=%b%b expected 1%b", i, dout_valid, dout_last,
                     i == 7);
         end
         tick();
      end
      n_checks++;
      if (stream !== 8'h01) begin
         n_fail++; $display("FAIL rstmid_stream: got %h expected 01", stream);
      end
   endtask

`ifdef BIT_SERIALIZER_REVERSE_EN
   task automatic test_reverse();
      logic [W-1:0] stream;
      logic [W-1:0] expect_stream;
      for (int r = 1; r >= 0; r--) begin
         stream = '0;
         expect_stream = (r == 1) ? 8'h80 : 8'h01;
         rev = (r == 1); din = 8'h01; din_valid = 1'b1; dout_ready = 1'b1;
         tick();
         din_valid = 1'b0;
         rev = (r != 1);  // flipping rev mid-word must not alter the word in flight
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            stream[7-i] = dout;
            tick();
         end
         n_checks++;
         if (stream !== expect_stream) begin
            n_fail++;
            $display("FAIL reverse_stream[rev=%0d]: got %h expected %h", r, stream, expect_stream);
         end
      end
      rev = 1'b0;
   endtask
`endif

   // Model: every accepted word becomes W queued bits; the stream must replay the queue.
   task automatic test_random();
      bit q_bit[$];
      bit q_last[$];
      bit busy;
      bit exp_ready;
      bit use_rev;
      for (int c = 0; c < 460; c++) begin
         din = W'($urandom);
         din_valid  = (c < 400) && ($urandom_range(0, 9) < 6);
         dout_ready = (c >= 400) || ($urandom_range(0, 9) < 7);
         use_rev = 1'b0;
`ifdef BIT_SERIALIZER_REVERSE_EN
         rev = 1'($urandom_range(0, 1));
         use_rev = rev;
`endif
         @(negedge clk);
         busy = (q_bit.size() != 0);
         exp_ready = !busy;
         if (busy && dout_ready && q_last[0]) exp_ready = 1'b1;
         n_checks++;
         if (dout_valid !== busy || din_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL rand_hs[%0d]: got valid=%b ready=%b expected %b/%b", c, dout_valid,
                     din_ready, busy, exp_ready);
         end
         if (busy) begin
            n_checks++;
            if (dout !== q_bit[0] || dout_last !== q_last[0]) begin
               n_fail++;
               $display("FAIL rand_bit[%0d]: got d/l=%b%b expected %b%b", c, dout, dout_last,
                        q_bit[0], q_last[0]);
            end
            if (dout_ready) begin
               void'(q_bit.pop_front());
               void'(q_last.pop_front());
            end
         end
         if (din_valid && exp_ready) begin
            for (int k = 0; k < W; k++) begin
               q_bit.push_back(use_rev ? din[k] : din[W-1-k]);
               q_last.push_back(k == W - 1);
            end
         end
         tick();
      end
      din_valid = 1'b0;
      n_checks++;
      if (q_bit.size() != 0) begin
         n_fail++; $display("FAIL rand_drain: got %0d bits pending expected 0", q_bit.size());
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset = 1'b1; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
`ifdef BIT_SERIALIZER_REVERSE_EN
      rev = 1'b0;
`endif
      test_reset();
      test_single_word();
      test_back_to_back();
      test_stall();
      test_busy_reject();
      test_reset_mid_word();
`ifdef BIT_SERIALIZER_REVERSE_EN
      test_reverse();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
